// File: rtl/scu_dsp_dma_pkg.sv
// Shared types for the SCU DSP DMA sequencer: FSM states, latched command
// and the reset/start state constants.
package scu_dsp_dma_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WACK = 2'd2,
        S_WEND = 2'd3
    } DMAState_t;

    // Bank field is sized for up to 256 banks; the top compares the whole
    // field so unused upper bits are always zero.
    localparam int BANK_W_MAX = 8;

    typedef struct packed {
        logic                  dir;
        logic [BANK_W_MAX-1:0] bank;
        logic                  hold;
    } DMACmd_t;

    localparam DMAState_t DMA_RESET_STATE = S_IDLE;
    localparam DMAState_t DMA_START_STATE = S_REQ;
    localparam DMACmd_t   DMA_CMD_RESET   = '0;

endpackage

// File: rtl/scu_dsp_dma_if.sv
// Bundle of sequencer, RAM and bus-side signals of the DMA sequencer.
// Handshake: DMA_REQ is a one-cycle word request; the bus answers with
// DMA_ACK while the engine waits (one word per ACK), and DMA_END closes the
// transfer. All signals are sampled only in CE=1 cycles.
interface scu_dsp_dma_if
    import scu_dsp_dma_pkg::*;
#(
    parameter int BANKS = 4,
    parameter int AW    = 6,
    parameter int DW    = 32,
    parameter int CNT_W = 8
);
    localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1;

    logic                  CE;
    logic                  ST;
    logic                  ST_DIR;
    logic [BW-1:0]         ST_BANK;
    logic [CNT_W-1:0]      ST_CNT;
    logic                  ST_HOLD;
    logic                  ABORT;
    logic [BANKS-1:0]      CT_WE;
    logic [AW-1:0]         CT_D;
    logic [BANKS-1:0]      CT_INC;
    logic [BANKS*AW-1:0]   CT;
    logic [BANKS*DW-1:0]   RAM_Q;
    logic [BANKS-1:0]      RAM_WE;
    logic [DW-1:0]         RAM_D;
    logic [DW-1:0]         DMA_DI;
    logic [DW-1:0]         DMA_DO;
    logic                  DMA_WE;
    logic                  DMA_REQ;
    logic                  DMA_ACK;
    logic                  DMA_END;
    logic                  DMA_RUN;
    logic                  DMA_LAST;
    logic                  DONE;
    DMAState_t             DBG_STATE;

    // The DMA engine side.
    modport master (
        input  CE, ST, ST_DIR, ST_BANK, ST_CNT, ST_HOLD, ABORT,
        input  CT_WE, CT_D, CT_INC, RAM_Q, DMA_DI, DMA_ACK, DMA_END,
        output CT, RAM_WE, RAM_D, DMA_DO, DMA_WE, DMA_REQ, DMA_RUN,
        output DMA_LAST, DONE, DBG_STATE
    );

    // The sequencer / RAM / bus arbiter side.
    modport slave (
        output CE, ST, ST_DIR, ST_BANK, ST_CNT, ST_HOLD, ABORT,
        output CT_WE, CT_D, CT_INC, RAM_Q, DMA_DI, DMA_ACK, DMA_END,
        input  CT, RAM_WE, RAM_D, DMA_DO, DMA_WE, DMA_REQ, DMA_RUN,
        input  DMA_LAST, DONE, DBG_STATE
    );

endinterface

// File: rtl/scu_dsp_dma_ctr.sv
// One bank address counter: load beats everything, otherwise the sequencer
// and DMA increments add together (up to +2), wrapping modulo 2^AW.
module scu_dsp_dma_ctr #(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce,
    input  logic          we,
    input  logic [AW-1:0] d,
    input  logic          inc,
    input  logic          dma_inc,
    output logic [AW-1:0] q
);

    logic [AW-1:0] ct_q;
    logic [AW-1:0] ct_d;

    // Next counter value: load or sum of both increment sources.
    always_comb begin
        if (we) begin
            ct_d = d;
        end else begin
            ct_d = ct_q + AW'(inc) + AW'(dma_inc);
        end
    end

    // Counter register, advancing only on clock-enabled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ct_q <= '0;
        end else if (ce) begin
            ct_q <= ct_d;
        end
    end

    assign q = ct_q;

endmodule

// File: rtl/scu_dsp_dma.sv
// SCU DSP DMA sequencer: word-by-word REQ/ACK/END transfer engine driving
// data RAM write strobes and owning the per-bank address counters.
module scu_dsp_dma
    import scu_dsp_dma_pkg::*;
#(
    parameter int BANKS = 4,
    parameter int AW    = 6,
    parameter int DW    = 32,
    parameter int CNT_W = 8
) (
    input  logic          CLK,
    input  logic          RST_N,
    scu_dsp_dma_if.master bus
);

    localparam int TW = CNT_W + 1;

    DMAState_t        state_q, state_d;
    DMACmd_t          cmd_q, cmd_d;
    logic [TW-1:0]    tn_q, tn_d;
    logic             req_q, req_d;
    logic             done_q, done_d;
    logic             ack_fire;
    logic [BANKS-1:0] ram_we;
    logic [BANKS-1:0] dma_inc;
    logic [DW-1:0]    dma_do;
    logic [BANKS*AW-1:0] ct;

    // Next-state logic: ABORT first, then END, then ACK; ST only in IDLE.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        tn_d     = tn_q;
        done_d   = 1'b0;
        ack_fire = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.ST) begin
                    cmd_d.dir  = bus.ST_DIR;
                    cmd_d.bank = BANK_W_MAX'(bus.ST_BANK);
                    cmd_d.hold = bus.ST_HOLD;
                    tn_d       = (bus.ST_CNT == '0) ? (TW'(1) << CNT_W)
                                                    : {1'b0, bus.ST_CNT};
                    state_d    = DMA_START_STATE;
                end
            end
            S_REQ: begin
                if (bus.ABORT) begin
                    state_d = S_IDLE;
                end else if (bus.DMA_END) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_WACK;
                end
            end
            S_WACK: begin
                if (bus.ABORT) begin
                    state_d = S_IDLE;
                end else begin
                    if (bus.DMA_ACK) begin
                        ack_fire = bus.CE;
                        tn_d     = tn_q - TW'(1);
                        state_d  = (tn_q > TW'(1)) ? S_REQ : S_WEND;
                    end
                    if (bus.DMA_END) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_WEND: begin
                if (bus.ABORT) begin
                    state_d = S_IDLE;
                end else if (bus.DMA_END) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        req_d = (state_d == S_REQ);
    end

    // FSM, command, transfer counter and pulse outputs; CE=0 holds all.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= DMA_RESET_STATE;
            cmd_q   <= DMA_CMD_RESET;
            tn_q    <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.CE) begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            tn_q    <= tn_d;
            req_q   <= req_d;
            done_q  <= done_d;
        end
    end

    // Bank decode for write strobes, DMA increments and read data mux.
    always_comb begin
        ram_we  = '0;
        dma_inc = '0;
        dma_do  = bus.RAM_Q[DW-1:0];
        for (int i = 0; i < BANKS; i++) begin
            if (cmd_q.bank == BANK_W_MAX'(i)) begin
                ram_we[i]  = ack_fire && !cmd_q.dir;
                dma_inc[i] = ack_fire && !cmd_q.hold;
                dma_do     = bus.RAM_Q[i*DW +: DW];
            end
        end
    end

    for (genvar g = 0; g < BANKS; g++) begin : g_ctr
        scu_dsp_dma_ctr #(.AW(AW)) u_ctr (
            .clk     (CLK),
            .rst_n   (RST_N),
            .ce      (bus.CE),
            .we      (bus.CT_WE[g]),
            .d       (bus.CT_D),
            .inc     (bus.CT_INC[g]),
            .dma_inc (dma_inc[g]),
            .q       (ct[g*AW +: AW])
        );
    end

    assign bus.CT        = ct;
    assign bus.RAM_WE    = ram_we;
    assign bus.RAM_D     = (|ram_we) ? bus.DMA_DI : '0;
    assign bus.DMA_DO    = dma_do;
    assign bus.DMA_WE    = (state_q != S_IDLE) && cmd_q.dir;
    assign bus.DMA_REQ   = req_q;
    assign bus.DMA_RUN   = (state_q != S_IDLE);
    assign bus.DMA_LAST  = (state_q != S_IDLE) && (tn_q == TW'(1));
    assign bus.DONE      = done_q;
    assign bus.DBG_STATE = state_q;

endmodule

// File: tb/tb_scu_dsp_dma.sv
// Directed bench for scu_dsp_dma: default instance plus an 8-bank instance.
module tb_scu_dsp_dma;
    import scu_dsp_dma_pkg::*;

    logic clk;
    logic rst_n;
    logic rst_n8;
    int   checks;
    int   errors;
    int   req_cnt;
    bit   reached;

    scu_dsp_dma_if #(.BANKS(4), .AW(6), .DW(32), .CNT_W(8)) bus ();
    scu_dsp_dma_if #(.BANKS(8), .AW(4), .DW(16), .CNT_W(8)) bus8 ();

    scu_dsp_dma #(.BANKS(4), .AW(6), .DW(32), .CNT_W(8)) u_dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    scu_dsp_dma #(.BANKS(8), .AW(4), .DW(16), .CNT_W(8)) u_dut8 (
        .CLK   (clk),
        .RST_N (rst_n8),
        .bus   (bus8)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic load_ct(input int bank, input logic [5:0] val);
        bus.CT_WE = 4'b0001 << bank;
        bus.CT_D  = val;
        tick();
        bus.CT_WE = '0;
        bus.CT_D  = '0;
    endtask

    task automatic start(input bit dir, input logic [1:0] bank, input logic [7:0] cnt, input bit hold);
        bus.ST      = 1'b1;
        bus.ST_DIR  = dir;
        bus.ST_BANK = bank;
        bus.ST_CNT  = cnt;
        bus.ST_HOLD = hold;
        tick();
        bus.ST      = 1'b0;
        bus.ST_DIR  = 1'b0;
        bus.ST_BANK = '0;
        bus.ST_CNT  = '0;
        bus.ST_HOLD = 1'b0;
    endtask

    task automatic finish_end();
        bus.DMA_END = 1'b1;
        tick();
        bus.DMA_END = 1'b0;
        chk("done_pulse", bus.DONE, 1'b1);
        chk("run_fall", bus.DMA_RUN, 1'b0);
        tick();
        chk("done_single", bus.DONE, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        rst_n8 = 1'b0;
        bus.CE = 1'b1; bus.ST = 1'b0; bus.ST_DIR = 1'b0; bus.ST_BANK = '0;
        bus.ST_CNT = '0; bus.ST_HOLD = 1'b0; bus.ABORT = 1'b0;
        bus.CT_WE = '0; bus.CT_D = '0; bus.CT_INC = '0;
        bus.RAM_Q = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
        bus.DMA_DI = '0; bus.DMA_ACK = 1'b0; bus.DMA_END = 1'b0;
        bus8.CE = 1'b1; bus8.ST = 1'b0; bus8.ST_DIR = 1'b0; bus8.ST_BANK = '0;
        bus8.ST_CNT = '0; bus8.ST_HOLD = 1'b0; bus8.ABORT = 1'b0;
        bus8.CT_WE = '0; bus8.CT_D = '0; bus8.CT_INC = '0;
        bus8.RAM_Q = {16'h7777, 16'h6666, 16'h5555, 16'h4444,
                      16'h3333, 16'h2222, 16'h1111, 16'h0000};
        bus8.DMA_DI = '0; bus8.DMA_ACK = 1'b0; bus8.DMA_END = 1'b0;
        #12;

        // reset state
        chk("rst_ct", bus.CT, 24'h0);
        chk("rst_run", bus.DMA_RUN, 1'b0);
        chk("rst_req", bus.DMA_REQ, 1'b0);
        chk("rst_done", bus.DONE, 1'b0);
        chk("rst_dma_we", bus.DMA_WE, 1'b0);
        chk("rst_ram_we", bus.RAM_WE, 4'h0);
        chk("rst_last", bus.DMA_LAST, 1'b0);
        chk("rst_dma_do", bus.DMA_DO, 32'hAAAA0000);
        rst_n  = 1'b1;
        rst_n8 = 1'b1;
        tick();

        // 1: DIR=0, bank 1 from address 5, three words
        load_ct(1, 6'd5);
        chk("ct1_load", bus.CT[11:6], 6'd5);
        start(1'b0, 2'd1, 8'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("t1_req", bus.DMA_REQ, 1'b1);
            chk("t1_run", bus.DMA_RUN, 1'b1);
            chk("t1_last", bus.DMA_LAST, (i == 2));
            chk("t1_we_idle", bus.RAM_WE, 4'h0);
            tick();
            chk("t1_req_low", bus.DMA_REQ, 1'b0);
            bus.DMA_ACK = 1'b1;
            bus.DMA_DI  = 32'h1111_0000 + i;
            #1;
            chk("t1_ram_we", bus.RAM_WE, 4'b0010);
            chk("t1_ram_d", bus.RAM_D, 32'h1111_0000 + i);
            chk("t1_addr", bus.CT[11:6], 6'd5 + 6'(i));
            tick();
            bus.DMA_ACK = 1'b0;
            bus.DMA_DI  = '0;
        end
        chk("t1_ct1_end", bus.CT[11:6], 6'd8);
        chk("t1_wend_req", bus.DMA_REQ, 1'b0);
        chk("t1_wend_run", bus.DMA_RUN, 1'b1);
        chk("t1_dma_we", bus.DMA_WE, 1'b0);
        finish_end();

        // 2: DIR=1, bank 3, hold, two words
        load_ct(3, 6'd10);
        start(1'b1, 2'd3, 8'd2, 1'b1);
        for (int i = 0; i < 2; i++) begin
            chk("t2_req", bus.DMA_REQ, 1'b1);
            chk("t2_dma_we", bus.DMA_WE, 1'b1);
            chk("t2_dma_do", bus.DMA_DO, 32'hDDDD0003);
            tick();
            bus.DMA_ACK = 1'b1;
            #1;
            chk("t2_ram_we", bus.RAM_WE, 4'h0);
            tick();
            bus.DMA_ACK = 1'b0;
            chk("t2_ct3", bus.CT[23:18], 6'd10);
        end
        finish_end();
        chk("t2_dma_we_idle", bus.DMA_WE, 1'b0);

        // 3: wrap 62 + 2 -> 0, then load beats ACK
        load_ct(2, 6'd62);
        start(1'b0, 2'd2, 8'd2, 1'b0);
        tick();
        bus.DMA_ACK = 1'b1;
        bus.CT_INC  = 4'b0100;
        tick();
        bus.DMA_ACK = 1'b0;
        bus.CT_INC  = '0;
        chk("t3_wrap", bus.CT[17:12], 6'd0);
        tick();
        bus.DMA_ACK = 1'b1;
        bus.CT_WE   = 4'b0100;
        bus.CT_D    = 6'd7;
        tick();
        bus.DMA_ACK = 1'b0;
        bus.CT_WE   = '0;
        bus.CT_D    = '0;
        chk("t3_load_wins", bus.CT[17:12], 6'd7);
        finish_end();

        // 4: count 0 means 256 words
        start(1'b1, 2'd0, 8'd0, 1'b0);
        bus.DMA_ACK = 1'b1;
        req_cnt = 0;
        reached = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (bus.DBG_STATE == S_WEND) begin
                reached = 1'b1;
                break;
            end
            if (bus.DMA_REQ) req_cnt++;
            tick();
        end
        bus.DMA_ACK = 1'b0;
        chk("t4_reached_wend", reached, 1'b1);
        chk("t4_req_count", req_cnt, 256);
        chk("t4_ct0", bus.CT[5:0], 6'd0);
        finish_end();

        // CE=0 freezes the REQ pulse
        start(1'b0, 2'd0, 8'd1, 1'b0);
        bus.CE = 1'b0;
        tick();
        tick();
        chk("ce_req_hold", bus.DMA_REQ, 1'b1);
        bus.CE = 1'b1;
        tick();
        chk("ce_req_drop", bus.DMA_REQ, 1'b0);
        bus.ABORT = 1'b1;
        tick();
        bus.ABORT = 1'b0;

        // 5: ABORT with second ACK; ST while busy ignored
        load_ct(0, 6'd20);
        start(1'b0, 2'd0, 8'd4, 1'b0);
        tick();
        bus.DMA_ACK = 1'b1;
        #1;
        chk("t5_first_we", bus.RAM_WE, 4'b0001);
        tick();
        bus.DMA_ACK = 1'b0;
        bus.ST = 1'b1; bus.ST_DIR = 1'b1; bus.ST_BANK = 2'd2; bus.ST_CNT = 8'd1;
        tick();
        bus.ST = 1'b0; bus.ST_DIR = 1'b0; bus.ST_BANK = '0; bus.ST_CNT = '0;
        chk("t5_busy_dir", bus.DMA_WE, 1'b0);
        chk("t5_busy_last", bus.DMA_LAST, 1'b0);
        chk("t5_busy_state", bus.DBG_STATE, S_WACK);
        bus.DMA_ACK = 1'b1;
        bus.ABORT   = 1'b1;
        #1;
        chk("t5_abort_we", bus.RAM_WE, 4'h0);
        tick();
        bus.DMA_ACK = 1'b0;
        bus.ABORT   = 1'b0;
        chk("t5_run", bus.DMA_RUN, 1'b0);
        chk("t5_done", bus.DONE, 1'b0);
        chk("t5_ct0", bus.CT[5:0], 6'd21);
        tick();
        chk("t5_done_after", bus.DONE, 1'b0);

        // 6: 8-bank instance, reset mid-transfer
        bus8.CT_WE = 8'b0010_0000;
        bus8.CT_D  = 4'd9;
        tick();
        bus8.CT_WE = '0;
        bus8.CT_D  = '0;
        bus8.ST = 1'b1; bus8.ST_BANK = 3'd5; bus8.ST_CNT = 8'd4;
        tick();
        bus8.ST = 1'b0; bus8.ST_BANK = '0; bus8.ST_CNT = '0;
        chk("t6_dma_do", bus8.DMA_DO, 16'h5555);
        tick();
        bus8.DMA_ACK = 1'b1;
        bus8.DMA_DI  = 16'hBEEF;
        #1;
        chk("t6_ram_we", bus8.RAM_WE, 8'b0010_0000);
        chk("t6_ram_d", bus8.RAM_D, 16'hBEEF);
        tick();
        bus8.DMA_ACK = 1'b0;
        bus8.DMA_DI  = '0;
        chk("t6_ct5", bus8.CT[23:20], 4'd10);
        chk("t6_req", bus8.DMA_REQ, 1'b1);
        rst_n8 = 1'b0;
        #1;
        chk("t6_rst_ct", bus8.CT, 32'h0);
        chk("t6_rst_run", bus8.DMA_RUN, 1'b0);
        chk("t6_rst_req", bus8.DMA_REQ, 1'b0);
        chk("t6_rst_done", bus8.DONE, 1'b0);
        tick();
        rst_n8 = 1'b1;
        tick();
        chk("t6_post_done", bus8.DONE, 1'b0);
        chk("t6_post_run", bus8.DMA_RUN, 1'b0);

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
